rmgmt_mem_arbiter: RTL and testbench

- Shares the single data-memory bus port between the standard core's execute-stage load/store path and the RISC-MGMT extension memory request path.
- The extension path carries the ts_pipe-side signals: req_mem, mem_addr, mem_store, mem_ren, mem_wen in; mem_load, mem_busy out.
- Sits between the two-stage pipeline / RISC-MGMT block and the generic data bus.
- Latches the winning request, holds it on the bus until the bus releases busy, then returns read data and drops the requester's busy.

---
 rtl/rmgmt_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_rmgmt_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmgmt_mem_arbiter.sv
`default_nettype none
// ============================================================================
// rmgmt_mem_arbiter: shares one data-bus port between the core load/store
// path and the RISC-MGMT extension memory path.     Revision: 1.0
// ============================================================================
module rmgmt_mem_arbiter #(
  parameter int EXT_PRIORITY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [ADDR_W-1:0] core_wdata,
  input  logic              core_ren,
  input  logic              core_wen,
  input  logic [3:0]        core_byte_en,
  output logic [ADDR_W-1:0] core_rdata,
  output logic              core_busy,
  input  logic              ext_req_mem,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [ADDR_W-1:0] ext_wdata,
  input  logic              ext_ren,
  input  logic              ext_wen,
  output logic [ADDR_W-1:0] ext_rdata,
  output logic              ext_busy,
  output logic              ext_misaligned,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [ADDR_W-1:0] bus_wdata,
  output logic              bus_ren,
  output logic              bus_wen,
  output logic [3:0]        bus_byte_en,
  input  logic [ADDR_W-1:0] bus_rdata,
  input  logic              bus_busy
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] GRANT_CORE = 2'd1;
  localparam logic [1:0] GRANT_EXT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wdata_q, wdata_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] core_rdata_q, ext_rdata_q;

  logic core_vld, ext_vld, ext_unaligned, ext_ok;
  logic bus_active, core_done, ext_done;
  logic grant_core, grant_ext;

  assign core_vld      = core_ren | core_wen;
  assign ext_vld       = ext_req_mem & (ext_ren | ext_wen);
  assign ext_unaligned = |ext_addr[1:0];
  assign ext_ok        = ext_vld & ~ext_unaligned;

  assign bus_active = (state_q == GRANT_CORE) || (state_q == GRANT_EXT);
  assign core_done  = (state_q == GRANT_CORE) & ~bus_busy;
  assign ext_done   = (state_q == GRANT_EXT) & ~bus_busy;

  // Completion hands the bus straight to a waiting peer; the finisher is never re-granted here.
  always_comb begin
    grant_core = 1'b0;
    grant_ext  = 1'b0;
    state_d    = state_q;
    case (state_q)
      IDLE: begin
        if (ext_ok && (!core_vld || EXT_PRIORITY != 0)) grant_ext = 1'b1;
        else if (core_vld)                               grant_core = 1'b1;
      end
      GRANT_CORE: begin
        grant_ext = core_done & ext_ok;
        if (core_done) state_d = IDLE;
      end
      GRANT_EXT: begin
        grant_core = ext_done & core_vld;
        if (ext_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (grant_core) state_d = GRANT_CORE;
    if (grant_ext)  state_d = GRANT_EXT;
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    be_d    = be_q;
    if (grant_core) begin
      addr_d  = core_addr;
      wdata_d = core_wdata;
      ren_d   = core_ren & ~core_wen;
      wen_d   = core_wen;
      be_d    = core_byte_en;
    end else if (grant_ext) begin
      addr_d  = ext_addr;
      wdata_d = ext_wdata;
      ren_d   = ext_ren & ~ext_wen;
      wen_d   = ext_wen;
      be_d    = 4'hF;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      be_q         <= 4'h0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      be_q    <= be_d;
      if (core_done && ren_q) core_rdata_q <= bus_rdata;
      if (ext_done && ren_q)  ext_rdata_q  <= bus_rdata;
    end
  end

  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_byte_en = be_q;
  assign bus_ren     = bus_active & ren_q;
  assign bus_wen     = bus_active & wen_q;

  assign core_rdata = (core_done && ren_q) ? bus_rdata : core_rdata_q;
  assign ext_rdata  = (ext_done && ren_q) ? bus_rdata : ext_rdata_q;

  // Misaligned extension requests are refused outright, so they never look busy.
  assign ext_misaligned = nRST & ext_vld & ext_unaligned;
  assign core_busy      = core_vld & ~core_done;
  assign ext_busy       = ext_vld & ~ext_misaligned & ~ext_done;

endmodule
`default_nettype wire

// File: tb/tb_rmgmt_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rmgmt_mem_arbiter: directed vector table, corner sequences and a random
// run against a transaction-level model, on both priority settings. Rev 1.0
// ============================================================================
module tb_rmgmt_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata, bus_rdata;
  logic        core_ren, core_wen, ext_req_mem, ext_ren, ext_wen, bus_busy;
  logic [3:0]  core_byte_en;

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic cb, eb, em, br, bw;
    logic [31:0] ba, bwd;
    logic [3:0]  bbe;
    logic [31:0] crd, erd;
  } out_t;

  out_t act [2];

  // Index k carries EXT_PRIORITY = k.
  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic        cb, eb, em, br, bw;
    logic [31:0] ba, bwd, crd, erd;
    logic [3:0]  bbe;
    rmgmt_mem_arbiter #(.EXT_PRIORITY(k), .ADDR_W(32)) u_dut (
      .CLK(CLK), .nRST(nRST),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_ren(core_ren),
      .core_wen(core_wen), .core_byte_en(core_byte_en), .core_rdata(crd), .core_busy(cb),
      .ext_req_mem(ext_req_mem), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_ren(ext_ren), .ext_wen(ext_wen), .ext_rdata(erd), .ext_busy(eb),
      .ext_misaligned(em),
      .bus_addr(ba), .bus_wdata(bwd), .bus_ren(br), .bus_wen(bw), .bus_byte_en(bbe),
      .bus_rdata(bus_rdata), .bus_busy(bus_busy)
    );
    assign act[k] = {cb, eb, em, br, bw, ba, bwd, bbe, crd, erd};
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, a, e);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                       input logic er, input logic ern, input logic ewn,
                       input logic [31:0] ea, input logic [31:0] ewd,
                       input logic bb, input logic [31:0] brd);
    core_ren = cr; core_wen = cw; core_addr = ca;
    core_wdata = ca ^ 32'hCAFE_0000; core_byte_en = 4'h3;
    ext_req_mem = er; ext_ren = ern; ext_wen = ewn; ext_addr = ea; ext_wdata = ewd;
    bus_busy = bb; bus_rdata = brd;
  endtask

  task automatic idle_in();
    drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic cr, cw; logic [31:0] ca;
    logic er, ern, ewn; logic [31:0] ea, ewd;
    logic bb; logic [31:0] brd;
    logic x_cb, x_eb, x_em, x_br, x_bw;
    logic [31:0] x_ba; logic [3:0] x_be;
    logic [31:0] x_crd, x_erd;
  } vec_t;

  function automatic vec_t mk(logic cr, logic cw, logic [31:0] ca,
                              logic er, logic ern, logic ewn, logic [31:0] ea, logic [31:0] ewd,
                              logic bb, logic [31:0] brd,
                              logic cb, logic eb, logic em, logic br, logic bw,
                              logic [31:0] ba, logic [3:0] be, logic [31:0] crd, logic [31:0] erd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.er = er; v.ern = ern; v.ewn = ewn;
    v.ea = ea; v.ewd = ewd; v.bb = bb; v.brd = brd;
    v.x_cb = cb; v.x_eb = eb; v.x_em = em; v.x_br = br; v.x_bw = bw;
    v.x_ba = ba; v.x_be = be; v.x_crd = crd; v.x_erd = erd;
    return v;
  endfunction

  vec_t tbl [19];

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr, wdata;
    logic ren, wen;
    logic [3:0] be;
  } req_t;

  int          owner [2];   // 0 = nobody, 1 = core, 2 = extension
  req_t        hold  [2];
  logic [31:0] m_crd [2];
  logic [31:0] m_erd [2];

  function automatic req_t core_req();
    return '{addr: core_addr, wdata: core_wdata, ren: core_ren & ~core_wen,
             wen: core_wen, be: core_byte_en};
  endfunction

  function automatic req_t ext_req();
    return '{addr: ext_addr, wdata: ext_wdata, ren: ext_ren & ~ext_wen,
             wen: ext_wen, be: 4'hF};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = 0; hold[k] = '0; m_crd[k] = 32'h0; m_erd[k] = 32'h0;
    end
  endtask

  task automatic model_check_and_step(input int k);
    bit cv, ev, mis, eok, fin;
    out_t a;
    a   = act[k];
    cv  = core_ren | core_wen;
    ev  = ext_req_mem & (ext_ren | ext_wen);
    mis = ev && (ext_addr[1:0] != 2'b00);
    eok = ev && !mis;
    fin = (owner[k] != 0) && !bus_busy;
    chk($sformatf("rnd p%0d core_busy", k), 32'(a.cb), 32'(cv && !(fin && owner[k] == 1)));
    chk($sformatf("rnd p%0d ext_busy", k), 32'(a.eb), 32'(eok && !(fin && owner[k] == 2)));
    chk($sformatf("rnd p%0d ext_misaligned", k), 32'(a.em), 32'(mis));
    chk($sformatf("rnd p%0d bus_ren", k), 32'(a.br), 32'(owner[k] != 0 && hold[k].ren));
    chk($sformatf("rnd p%0d bus_wen", k), 32'(a.bw), 32'(owner[k] != 0 && hold[k].wen));
    if (owner[k] != 0) begin
      chk($sformatf("rnd p%0d bus_addr", k), a.ba, hold[k].addr);
      chk($sformatf("rnd p%0d bus_wdata", k), a.bwd, hold[k].wdata);
      chk($sformatf("rnd p%0d bus_byte_en", k), 32'(a.bbe), 32'(hold[k].be));
    end
    if (fin && hold[k].ren) begin
      if (owner[k] == 1) m_crd[k] = bus_rdata;
      else               m_erd[k] = bus_rdata;
    end
    chk($sformatf("rnd p%0d core_rdata", k), a.crd, m_crd[k]);
    chk($sformatf("rnd p%0d ext_rdata", k), a.erd, m_erd[k]);
    // advance to the owner after this clock edge
    if (owner[k] == 0) begin
      if (eok && (!cv || k == 1)) begin owner[k] = 2; hold[k] = ext_req(); end
      else if (cv)                begin owner[k] = 1; hold[k] = core_req(); end
    end else if (fin) begin
      if (owner[k] == 1 && eok)     begin owner[k] = 2; hold[k] = ext_req(); end
      else if (owner[k] == 2 && cv) begin owner[k] = 1; hold[k] = core_req(); end
      else owner[k] = 0;
    end
  endtask

  initial begin
    tbl[0]  = mk(1,0,32'h100, 0,0,0,32'h0,32'h0, 0,32'hDEADBEEF, 1,0,0,0,0, 32'h0,4'h0, 32'h0,32'h0);
    tbl[1]  = mk(1,0,32'h100, 0,0,0,32'h0,32'h0, 0,32'hDEADBEEF, 0,0,0,1,0, 32'h100,4'h3, 32'hDEADBEEF,32'h0);
    tbl[2]  = mk(0,0,32'h0, 0,0,0,32'h0,32'h0, 0,32'h0, 0,0,0,0,0, 32'h0,4'h0, 32'hDEADBEEF,32'h0);
    tbl[3]  = mk(0,0,32'h0, 1,0,1,32'h200,32'h12345678, 1,32'h0, 0,1,0,0,0, 32'h0,4'h0, 32'hDEADBEEF,32'h0);
    tbl[4]  = mk(0,0,32'h0, 1,0,1,32'h200,32'h12345678, 1,32'h0, 0,1,0,0,1, 32'h200,4'hF, 32'hDEADBEEF,32'h0);
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = mk(0,0,32'h0, 1,0,1,32'h200,32'h12345678, 0,32'h0, 0,0,0,0,1, 32'h200,4'hF, 32'hDEADBEEF,32'h0);
    tbl[8]  = tbl[2];
    tbl[9]  = mk(1,0,32'h10, 1,1,0,32'h20,32'h0, 0,32'h11111111, 1,1,0,0,0, 32'h0,4'h0, 32'hDEADBEEF,32'h0);
    tbl[10] = mk(1,0,32'h10, 1,1,0,32'h20,32'h0, 0,32'h22222222, 1,0,0,1,0, 32'h20,4'hF, 32'hDEADBEEF,32'h22222222);
    tbl[11] = mk(1,0,32'h10, 0,0,0,32'h0,32'h0, 0,32'h33333333, 0,0,0,1,0, 32'h10,4'h3, 32'h33333333,32'h22222222);
    tbl[12] = mk(0,0,32'h0, 0,0,0,32'h0,32'h0, 0,32'h0, 0,0,0,0,0, 32'h0,4'h0, 32'h33333333,32'h22222222);
    tbl[13] = mk(0,1,32'h40, 1,1,0,32'h203,32'h0, 0,32'h0, 1,0,1,0,0, 32'h0,4'h0, 32'h33333333,32'h22222222);
    tbl[14] = mk(0,1,32'h40, 0,0,0,32'h0,32'h0, 0,32'h0, 0,0,0,0,1, 32'h40,4'h3, 32'h33333333,32'h22222222);
    tbl[15] = tbl[12];
    tbl[16] = mk(0,0,32'h0, 1,1,1,32'h300,32'hABCD0300, 0,32'h55555555, 0,1,0,0,0, 32'h0,4'h0, 32'h33333333,32'h22222222);
    tbl[17] = mk(0,0,32'h0, 1,1,1,32'h300,32'hABCD0300, 0,32'h55555555, 0,0,0,0,1, 32'h300,4'hF, 32'h33333333,32'h22222222);
    tbl[18] = tbl[12];

    idle_in();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // ---- table on the extension-priority instance ----
    for (int i = 0; i < 19; i++) begin
      @(negedge CLK);
      drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].er, tbl[i].ern, tbl[i].ewn,
            tbl[i].ea, tbl[i].ewd, tbl[i].bb, tbl[i].brd);
      #2;
      chk($sformatf("vec%0d core_busy", i), 32'(act[1].cb), 32'(tbl[i].x_cb));
      chk($sformatf("vec%0d ext_busy", i), 32'(act[1].eb), 32'(tbl[i].x_eb));
      chk($sformatf("vec%0d ext_misaligned", i), 32'(act[1].em), 32'(tbl[i].x_em));
      chk($sformatf("vec%0d bus_ren", i), 32'(act[1].br), 32'(tbl[i].x_br));
      chk($sformatf("vec%0d bus_wen", i), 32'(act[1].bw), 32'(tbl[i].x_bw));
      chk($sformatf("vec%0d core_rdata", i), act[1].crd, tbl[i].x_crd);
      chk($sformatf("vec%0d ext_rdata", i), act[1].erd, tbl[i].x_erd);
      if (tbl[i].x_br || tbl[i].x_bw) begin
        chk($sformatf("vec%0d bus_addr", i), act[1].ba, tbl[i].x_ba);
        chk($sformatf("vec%0d bus_byte_en", i), 32'(act[1].bbe), 32'(tbl[i].x_be));
      end
    end

    // ---- simultaneous requests: core-priority order vs extension-priority order ----
    @(negedge CLK);
    drive(1,0,32'h10, 1,1,0,32'h20,32'h0, 0,32'h0); #2;
    chk("prio0 idle bus_ren", 32'(act[0].br), 32'h0);
    chk("prio0 idle core_busy", 32'(act[0].cb), 32'h1);
    @(negedge CLK);
    drive(1,0,32'h10, 1,1,0,32'h20,32'h0, 0,32'hAAAA0001); #2;
    chk("prio0 first bus_addr", act[0].ba, 32'h10);
    chk("prio0 first core_busy", 32'(act[0].cb), 32'h0);
    chk("prio0 first ext_busy", 32'(act[0].eb), 32'h1);
    chk("prio0 first core_rdata", act[0].crd, 32'hAAAA0001);
    chk("prio1 first bus_addr", act[1].ba, 32'h20);
    chk("prio1 first ext_rdata", act[1].erd, 32'hAAAA0001);
    @(negedge CLK);
    drive(0,0,32'h0, 1,1,0,32'h20,32'h0, 0,32'hBBBB0002); #2;
    chk("prio0 second bus_ren", 32'(act[0].br), 32'h1);
    chk("prio0 second bus_addr", act[0].ba, 32'h20);
    chk("prio0 second ext_rdata", act[0].erd, 32'hBBBB0002);
    chk("prio1 second bus_addr", act[1].ba, 32'h10);
    chk("prio1 second core_rdata", act[1].crd, 32'hBBBB0002);
    repeat (2) begin @(negedge CLK); idle_in(); end

    // ---- asynchronous reset in the middle of a core transfer ----
    @(negedge CLK);
    drive(1,0,32'h500, 0,0,0,32'h0,32'h0, 1,32'h0);
    @(negedge CLK); #2;
    chk("rst pre bus_ren", 32'(act[1].br), 32'h1);
    chk("rst pre bus_addr", act[1].ba, 32'h500);
    nRST = 1'b0; #1;
    chk("rst async bus_ren", 32'(act[1].br), 32'h0);
    chk("rst async bus_wen", 32'(act[1].bw), 32'h0);
    chk("rst async core_rdata", act[1].crd, 32'h0);
    chk("rst async ext_rdata", act[1].erd, 32'h0);
    chk("rst async core_busy", 32'(act[1].cb), 32'h1);
    chk("rst async p0 bus_ren", 32'(act[0].br), 32'h0);
    drive(1,0,32'h600, 0,0,0,32'h0,32'h0, 0,32'h600D600D);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1; #2;
    chk("rst after idle bus_ren", 32'(act[1].br), 32'h0);
    chk("rst after idle core_busy", 32'(act[1].cb), 32'h1);
    @(negedge CLK); #2;
    chk("rst after done bus_ren", 32'(act[1].br), 32'h1);
    chk("rst after done bus_addr", act[1].ba, 32'h600);
    chk("rst after done core_busy", 32'(act[1].cb), 32'h0);
    chk("rst after done core_rdata", act[1].crd, 32'h600D600D);

    // ---- randomized run against the model ----
    @(negedge CLK);
    idle_in();
    nRST = 1'b0;
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 9) < 4) begin
        core_ren     = ($urandom_range(0, 2) == 0);
        core_wen     = ($urandom_range(0, 2) == 0);
        core_addr    = 32'($urandom_range(0, 4095)) << 2;
        core_wdata   = $urandom;
        core_byte_en = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 9) < 4) begin
        ext_req_mem = ($urandom_range(0, 3) != 0);
        ext_ren     = ($urandom_range(0, 1) == 0);
        ext_wen     = ($urandom_range(0, 2) == 0);
        ext_addr    = (32'($urandom_range(0, 4095)) << 2) |
                      (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
        ext_wdata   = $urandom;
      end
      bus_busy  = ($urandom_range(0, 9) < 4);
      bus_rdata = $urandom;
      #2;
      model_check_and_step(0);
      model_check_and_step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
